// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  // Host-to-device frame after the start bit: {stop, odd parity, data}, sent LSB first.
  function automatic logic [9:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Pad conditioning for a PS/2 clock/data pair: 2-flop synchronizers, a FILTER_LEN
// glitch filter on the clock and a one-cycle falling-edge strobe. Idle bus level is 1.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_raw,
  input  logic data_raw,
  output logic clk_filt,
  output logic data_sync,
  output logic clk_fe
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q;
  logic          filt_d_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_d_q    <= 1'b1;
      cnt_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], clk_raw};
      data_sync_q <= {data_sync_q[0], data_raw};
      filt_d_q    <= filt_q;
      // Any sample that agrees with the accepted level restarts the run.
      if (clk_sync_q[1] != filt_q) begin
        if (cnt_q == CW'(FILTER_LEN - 1)) begin
          filt_q <= clk_sync_q[1];
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign clk_filt  = filt_q;
  assign data_sync = data_sync_q[1];
  assign clk_fe    = filt_d_q & ~filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits +
// odd parity + stop on device clocks, then ACK. Option macro: PS2_HOST_TX_ACK_CHECK_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [2:0] dbg_state
);

  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

`ifdef PS2_HOST_TX_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          drive_q, drive_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          clk_filt, data_sync, clk_fe;
  logic          nack_err;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .reset     (reset),
    .clk_raw   (ps2_clk_in),
    .data_raw  (ps2_data_in),
    .clk_filt  (clk_filt),
    .data_sync (data_sync),
    .clk_fe    (clk_fe)
  );

  assign nack_err = ACK_CHECK & ack_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      inh_q   <= '0;
      to_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      drive_q <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inh_q   <= inh_d;
      to_q    <= to_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      drive_q <= drive_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Handshake: tx_data is captured in the cycle where tx_valid && tx_ready; tx_ready is
  // high only in IDLE, so requests made while a frame is in flight are dropped.
  always_comb begin
    state_d     = state_q;
    inh_d       = inh_q;
    to_d        = to_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    drive_d     = drive_q;
    ack_d       = ack_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;

    case (state_q)
      IDLE: begin
        inh_d = '0;
        to_d  = '0;
        if (tx_valid) begin
          shift_d = make_frame(tx_data);
          bit_d   = '0;
          drive_d = 1'b0;
          ack_d   = 1'b0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        to_d       = '0;
        if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
          ps2_data_oe = 1'b1;
          inh_d       = '0;
          state_d     = RTS;
        end else begin
          inh_d = inh_q + IW'(1);
        end
      end
      RTS: begin
        ps2_data_oe = 1'b1;
        bit_d       = '0;
        if (clk_fe) begin
          drive_d = ~shift_q[0];
          shift_d = {1'b0, shift_q[9:1]};
          bit_d   = 4'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ps2_data_oe = drive_q;
        if (clk_fe) begin
          drive_d = ~shift_q[0];
          shift_d = {1'b0, shift_q[9:1]};
          bit_d   = (bit_q == 4'hF) ? bit_q : bit_q + 4'd1;
          if (bit_q == 4'd9) state_d = ACK;
        end
      end
      ACK: begin
        if (clk_fe) begin
          ack_d   = data_sync;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_filt && data_sync) begin
          state_d = IDLE;
          if (nack_err) err_d = 1'b1;
          else          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The device-response window is bounded; expiry overrides any other transition.
    if (state_q inside {RTS, SHIFT, ACK, WAIT_IDLE}) begin
      if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        done_d  = 1'b0;
        err_d   = 1'b1;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
  end

  assign tx_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign tx_done   = done_q;
  assign tx_err    = err_q;
  assign dbg_state = state_q;

endmodule
